// File: rtl/mem_wb_lsu.sv
`default_nettype none
// ============================================================================
// mem_wb_lsu : memory stage (word LSU over a req/ack port) + MEM/WB register
// Rev 1.0
// ============================================================================
module mem_wb_lsu #(
    parameter int XLEN    = 32,
    parameter int RD_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                RegWriteM,
    input  logic                MemWriteM,
    input  logic                ResultSrcM,
    input  logic                FPRegWriteM,
    input  logic                FPResultSrcM,
    input  logic [RD_BITS-1:0]  RD_M,
    input  logic [RD_BITS-1:0]  FP_RD_M,
    input  logic [XLEN-1:0]     PCPlus4M,
    input  logic [XLEN-1:0]     ALU_ResultM,
    input  logic [XLEN-1:0]     WriteDataM,
    input  logic [XLEN-1:0]     FP_ALU_ResultM,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_ack,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                mem_stall,
    output logic                misalign_exc,
    output logic                RegWriteW,
    output logic                FPRegWriteW,
    output logic [RD_BITS-1:0]  RD_W,
    output logic [RD_BITS-1:0]  FP_RD_W,
    output logic [XLEN-1:0]     ResultW,
    output logic [XLEN-1:0]     FPResultW,
    output logic [XLEN-1:0]     PCPlus4W
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              memop;
    logic              misal;
    logic              launch;
    logic              req_q;
    logic              we_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   load_q;

    always_comb begin
        memop     = MemWriteM | ResultSrcM | FPResultSrcM;
        misal     = memop & (ALU_ResultM[1:0] != 2'b00);
        launch    = (state == IDLE) & memop & ~misal;
        // Gated by reset so the upstream freeze releases the instant reset hits.
        mem_stall = rst & (launch | (state == BUSY));
        state_nxt = state;
        case (state)
            IDLE:    if (launch)   state_nxt = BUSY;
            BUSY:    if (dmem_ack) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus request register: launched from IDLE only, held until the ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
        end else if (launch) begin
            req_q   <= 1'b1;
            we_q    <= MemWriteM;
            addr_q  <= ALU_ResultM;
            wdata_q <= WriteDataM;
        end else if ((state == BUSY) && dmem_ack) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            load_q  <= dmem_rdata;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

    // MEM/WB register: flush beats stall beats misalignment beats capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW    <= 1'b0;
            FPRegWriteW  <= 1'b0;
            RD_W         <= '0;
            FP_RD_W      <= '0;
            ResultW      <= '0;
            FPResultW    <= '0;
            PCPlus4W     <= '0;
            misalign_exc <= 1'b0;
        end else if (flush || mem_stall || misal) begin
            RegWriteW    <= 1'b0;
            FPRegWriteW  <= 1'b0;
            RD_W         <= '0;
            FP_RD_W      <= '0;
            ResultW      <= '0;
            FPResultW    <= '0;
            PCPlus4W     <= '0;
            misalign_exc <= ~flush & ~mem_stall & misal;
        end else begin
            RegWriteW    <= RegWriteM;
            FPRegWriteW  <= FPRegWriteM;
            RD_W         <= RD_M;
            FP_RD_W      <= FP_RD_M;
            ResultW      <= ResultSrcM ? load_q : ALU_ResultM;
            FPResultW    <= FPResultSrcM ? load_q : FP_ALU_ResultM;
            PCPlus4W     <= PCPlus4M;
            misalign_exc <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_lsu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mem_wb_lsu : scoreboard bench for the memory stage / MEM/WB register
// Rev 1.0
// ============================================================================
module tb_mem_wb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        RegWriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0;
    logic        FPRegWriteM = 1'b0, FPResultSrcM = 1'b0;
    logic [4:0]  RD_M = '0, FP_RD_M = '0;
    logic [31:0] PCPlus4M = '0, ALU_ResultM = '0, WriteDataM = '0, FP_ALU_ResultM = '0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic        mem_stall, misalign_exc, RegWriteW, FPRegWriteW;
    logic [4:0]  RD_W, FP_RD_W;
    logic [31:0] ResultW, FPResultW, PCPlus4W;

    mem_wb_lsu dut (
        .clk(clk), .rst(rst), .flush(flush),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .FPRegWriteM(FPRegWriteM), .FPResultSrcM(FPResultSrcM),
        .RD_M(RD_M), .FP_RD_M(FP_RD_M), .PCPlus4M(PCPlus4M),
        .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .FP_ALU_ResultM(FP_ALU_ResultM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .misalign_exc(misalign_exc),
        .RegWriteW(RegWriteW), .FPRegWriteW(FPRegWriteW),
        .RD_W(RD_W), .FP_RD_W(FP_RD_W),
        .ResultW(ResultW), .FPResultW(FPResultW), .PCPlus4W(PCPlus4W)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        frw;
        logic [4:0]  rd;
        logic [4:0]  frd;
        logic [31:0] res;
        logic [31:0] fres;
        logic [31:0] pc;
    } wb_t;

    wb_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: ack after mem_lat wait cycles; rdata is junk except with ack.
    int          mem_lat = 0;
    int          wait_cnt = 0;
    int          ack_cnt = 0;
    logic [31:0] mem_data = '0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;

    always @(negedge clk) begin
        if (rst && dmem_req && !dmem_ack) begin
            if (wait_cnt >= mem_lat) begin
                dmem_ack   = 1'b1;
                dmem_rdata = mem_data;
                ack_cnt++;
                if (dmem_we) begin
                    last_waddr = dmem_addr;
                    last_wdata = dmem_wdata;
                end
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            dmem_ack   = 1'b0;
            dmem_rdata = 32'hBAD0_BAD0;
            wait_cnt   = 0;
        end
    end

    // Monitor: per-test counters plus scoreboard pop on every writeback.
    int          stall_cnt = 0, req_cnt = 0, we_cnt = 0, exc_cnt = 0;
    logic        req_prev = 1'b0;
    logic [31:0] addr_prev = '0;

    always @(negedge clk) begin
        wb_t e;
        if (rst) begin
            if (mem_stall) stall_cnt++;
            if (misalign_exc) exc_cnt++;
            if (dmem_req) begin
                req_cnt++;
                if (dmem_we) we_cnt++;
                if (req_prev) check("addr_hold", dmem_addr, addr_prev);
                addr_prev = dmem_addr;
            end
            req_prev = dmem_req;
            if (RegWriteW || FPRegWriteW) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_wb", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("RegWriteW", {31'd0, RegWriteW}, {31'd0, e.rw});
                    check("FPRegWriteW", {31'd0, FPRegWriteW}, {31'd0, e.frw});
                    if (e.rw) begin
                        check("RD_W", {27'd0, RD_W}, {27'd0, e.rd});
                        check("ResultW", ResultW, e.res);
                    end
                    if (e.frw) begin
                        check("FP_RD_W", {27'd0, FP_RD_W}, {27'd0, e.frd});
                        check("FPResultW", FPResultW, e.fres);
                    end
                    check("PCPlus4W", PCPlus4W, e.pc);
                end
            end
        end else begin
            req_prev = 1'b0;
        end
    end

    task automatic clr();
        stall_cnt = 0; req_cnt = 0; we_cnt = 0; exc_cnt = 0; ack_cnt = 0;
    endtask

    task automatic drive_nop();
        flush = 1'b0; RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0;
        FPRegWriteM = 1'b0; FPResultSrcM = 1'b0; RD_M = '0; FP_RD_M = '0;
        PCPlus4M = '0; ALU_ResultM = '0; WriteDataM = '0; FP_ALU_ResultM = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one instruction at the M stage and hold it until it is consumed.
    task automatic exec(input logic rw, input logic frw, input logic mw,
                        input logic rs, input logic frs,
                        input logic [4:0] rd, input logic [4:0] frd,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] fpalu, input logic [31:0] pc,
                        input logic fl, output int cyc);
        wb_t  e;
        logic mis;
        logic stl;
        bit   done;
        RegWriteM = rw; FPRegWriteM = frw; MemWriteM = mw; ResultSrcM = rs;
        FPResultSrcM = frs; RD_M = rd; FP_RD_M = frd; ALU_ResultM = alu;
        WriteDataM = wd; FP_ALU_ResultM = fpalu; PCPlus4M = pc; flush = fl;
        mis = (mw | rs | frs) && (alu[1:0] != 2'b00);
        if (!fl && !mis && (rw || frw)) begin
            e.rw = rw; e.frw = frw; e.rd = rd; e.frd = frd; e.pc = pc;
            e.res  = rs  ? mem_data : alu;
            e.fres = frs ? mem_data : fpalu;
            sb.push_back(e);
        end
        cyc  = 0;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            stl = mem_stall;
            @(posedge clk);
            cyc++;
            if (!stl) done = 1'b1;
        end
        if (!done) check("exec_timeout", 32'd1, 32'd0);
        #1;
        drive_nop();
    endtask

    initial begin
        int cyc;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        drive_nop();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_misalign", {31'd0, misalign_exc}, 32'd0);
        check("rst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        check("rst_ResultW", ResultW, 32'd0);
        check("rst_PCPlus4W", PCPlus4W, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);

        // ALU op
        clr();
        exec(1, 0, 0, 0, 0, 5'd5, 5'd0, 32'h1234, 32'h0, 32'h0, 32'h44, 0, cyc);
        idle(2);
        check("alu_cycles", cyc, 32'd1);
        check("alu_stall", stall_cnt, 32'd0);

        // Integer load, ack two cycles after the request
        clr(); mem_lat = 2; mem_data = 32'hDEADBEEF;
        exec(1, 0, 0, 1, 0, 5'd7, 5'd0, 32'h100, 32'h0, 32'h0, 32'h48, 0, cyc);
        idle(2);
        check("load_cycles", cyc, 32'd5);
        check("load_stall", stall_cnt, 32'd4);
        check("load_req", req_cnt, 32'd3);
        check("load_we", we_cnt, 32'd0);
        check("load_ack", ack_cnt, 32'd1);

        // Store, same-cycle ack
        clr(); mem_lat = 0; mem_data = 32'h0BAD_F00D;
        exec(0, 0, 1, 0, 0, 5'd9, 5'd0, 32'h8, 32'hA5A5A5A5, 32'h0, 32'h4C, 0, cyc);
        idle(2);
        check("store_cycles", cyc, 32'd3);
        check("store_stall", stall_cnt, 32'd2);
        check("store_req", req_cnt, 32'd1);
        check("store_we", we_cnt, 32'd1);
        check("store_addr", last_waddr, 32'h8);
        check("store_data", last_wdata, 32'hA5A5A5A5);

        // FP load, then a plain FP-ALU writeback
        clr(); mem_lat = 1; mem_data = 32'h3F800000;
        exec(0, 1, 0, 0, 1, 5'd0, 5'd3, 32'h20, 32'h0, 32'h1111, 32'h50, 0, cyc);
        check("fpload_cycles", cyc, 32'd4);
        exec(0, 1, 0, 0, 0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h40490FDB, 32'h54, 0, cyc);
        idle(2);
        check("fpalu_cycles", cyc, 32'd1);

        // Misaligned load is dropped
        clr();
        exec(1, 0, 0, 1, 0, 5'd4, 5'd0, 32'h102, 32'h0, 32'h0, 32'h58, 0, cyc);
        idle(2);
        check("misal_cycles", cyc, 32'd1);
        check("misal_req", req_cnt, 32'd0);
        check("misal_exc", exc_cnt, 32'd1);
        check("misal_stall", stall_cnt, 32'd0);

        // Flush through a load: bus completes, no writeback
        clr(); mem_lat = 1; mem_data = 32'h12345678;
        exec(1, 0, 0, 1, 0, 5'd6, 5'd0, 32'h40, 32'h0, 32'h0, 32'h5C, 1, cyc);
        idle(2);
        check("flush_cycles", cyc, 32'd4);
        check("flush_ack", ack_cnt, 32'd1);
        check("flush_req", req_cnt, 32'd2);

        // Asynchronous reset in the middle of a long access
        clr(); mem_lat = 1000;
        RegWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd8; ALU_ResultM = 32'h200;
        repeat (3) @(posedge clk);
        #2;
        check("busy_req_before_rst", {31'd0, dmem_req}, 32'd1);
        rst = 1'b0;
        #1;
        check("arst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("arst_mem_stall", {31'd0, mem_stall}, 32'd0);
        check("arst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        check("arst_ResultW", ResultW, 32'd0);
        drive_nop();
        @(posedge clk); #1;
        rst = 1'b1; mem_lat = 0;
        clr();
        exec(1, 0, 0, 0, 0, 5'd10, 5'd0, 32'hCAFE, 32'h0, 32'h0, 32'h60, 0, cyc);
        idle(2);
        check("post_rst_cycles", cyc, 32'd1);
        check("post_rst_stall", stall_cnt, 32'd0);

        idle(3);
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
